// File: rtl/uart_mmio_ctrl_pkg.sv
// uart_mmio_ctrl_pkg: register offsets, CON bit positions and FSM encodings shared by the UART controller.
package uart_mmio_ctrl_pkg;
  localparam logic [1:0] UART_TXD = 2'd0;
  localparam logic [1:0] UART_RXD = 2'd1;
  localparam logic [1:0] UART_CON = 2'd2;
  localparam int CON_RX_VALID  = 0;
  localparam int CON_TX_BUSY   = 1;
  localparam int CON_OVERRUN   = 2;
  localparam int CON_FRAME_ERR = 3;
  localparam int CON_TX_LOST   = 4;
  localparam int CON_IRQ_EN    = 5;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small receive byte FIFO; a push while full is accepted only if a pop frees a slot that cycle.
module uart_rx_fifo
  import uart_mmio_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign head  = mem_q[rd_ptr_q];
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_ptr_q] <= din;
endmodule

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped 8N1 UART with TXD/RXD/CON registers, RX byte FIFO, sticky error flags and irq.
module uart_mmio_ctrl
  import uart_mmio_ctrl_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        SystemClk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        RX,
  output logic        TX,
  output logic        irq
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bits_q, tx_bits_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_q, tx_d, tx_lost_q, tx_lost_d;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]    rx_bits_q, rx_bits_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic          overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic          irq_en_q, irq_en_d, irq_q, irq_d;
  logic          tx_wr, con_wr, rx_pop, rx_push, fe_set, tx_busy, tx_tick, rx_tick;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [31:0]   con;
  assign tx_wr   = wr_en & (addr == UART_TXD);
  assign con_wr  = wr_en & (addr == UART_CON);
  assign rx_pop  = rd_en & (addr == UART_RXD);
  assign tx_busy = tx_state_q != TX_IDLE;
  assign tx_tick = tx_cnt_q == BIT_END;
  assign rx_tick = rx_cnt_q == BIT_END;
  assign TX      = tx_q;
  assign irq     = irq_q;
  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (SystemClk),
    .rst  (reset),
    .push (rx_push),
    .din  (rx_sh_q),
    .pop  (rx_pop),
    .head (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_state_q == TX_IDLE ? '0 : (tx_tick ? '0 : tx_cnt_q + 1'b1);
    tx_bits_d  = tx_bits_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    unique case (tx_state_q)
      TX_IDLE:
        if (tx_wr) begin
          tx_state_d = TX_START;
          tx_d       = 1'b0;
          tx_sh_d    = wdata[7:0];
        end
      TX_START:
        if (tx_tick) begin
          tx_state_d = TX_DATA;
          tx_d       = tx_sh_q[0];
          tx_sh_d    = tx_sh_q >> 1;
          tx_bits_d  = 4'd1;
        end
      TX_DATA:
        if (tx_tick) begin
          tx_state_d = tx_bits_q == 4'd8 ? TX_STOP : TX_DATA;
          tx_d       = tx_bits_q == 4'd8 ? 1'b1 : tx_sh_q[0];
          tx_sh_d    = tx_sh_q >> 1;
          tx_bits_d  = tx_bits_q == 4'd8 ? tx_bits_q : tx_bits_q + 4'd1;
        end
      TX_STOP:
        if (tx_tick) tx_state_d = TX_IDLE;
    endcase
  end
  // Sampling runs on the synchronised line; START waits half a bit so later samples land mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_state_q == RX_IDLE ? '0 : rx_cnt_q + 1'b1;
    rx_bits_d  = rx_bits_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    fe_set     = 1'b0;
    unique case (rx_state_q)
      RX_IDLE:
        if (rx_prev_q & ~rx_s2_q) rx_state_d = RX_START;
      RX_START:
        if (rx_cnt_q == HALF_END) begin
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
          rx_cnt_d   = '0;
          rx_bits_d  = '0;
        end
      RX_DATA:
        if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_sh_d    = {rx_s2_q, rx_sh_q[7:1]};
          rx_bits_d  = rx_bits_q + 4'd1;
          rx_state_d = rx_bits_q == 4'd7 ? RX_STOP : RX_DATA;
        end
      RX_STOP:
        if (rx_tick) begin
          rx_state_d = RX_IDLE;
          rx_push    = rx_s2_q;
          fe_set     = ~rx_s2_q;
        end
    endcase
  end
  always_comb begin
    tx_lost_d   = (tx_lost_q & ~(con_wr & wdata[CON_TX_LOST])) | (tx_wr & tx_busy);
    overrun_d   = (overrun_q & ~(con_wr & wdata[CON_OVERRUN])) | (rx_push & fifo_full & ~rx_pop);
    frame_err_d = (frame_err_q & ~(con_wr & wdata[CON_FRAME_ERR])) | fe_set;
    irq_en_d    = con_wr ? wdata[CON_IRQ_EN] : irq_en_q;
    irq_d       = irq_en_q & (~fifo_empty | overrun_q | frame_err_q);
    con         = {26'b0, irq_en_q, tx_lost_q, frame_err_q, overrun_q, tx_busy, ~fifo_empty};
    rdata       = addr == UART_CON ? con :
                  (addr == UART_RXD && !fifo_empty) ? {24'b0, fifo_head} : 32'b0;
  end
  always_ff @(posedge SystemClk or posedge reset)
    if (reset) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bits_q   <= '0;
      tx_sh_q     <= '0;
      tx_q        <= 1'b1;
      tx_lost_q   <= 1'b0;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bits_q   <= '0;
      rx_sh_q     <= '0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bits_q   <= tx_bits_d;
      tx_sh_q     <= tx_sh_d;
      tx_q        <= tx_d;
      tx_lost_q   <= tx_lost_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bits_q   <= rx_bits_d;
      rx_sh_q     <= rx_sh_d;
      rx_s1_q     <= RX;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
    end
endmodule
